// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider: FSM state
// encoding and the default operand width.
package div_pkg;

  localparam int DEF_WIDTH = 16;

  // 2'b11 is unused and falls back to IDLE in the next-state logic.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/div_datapath.sv
// Datapath for the repeated-subtraction divider: running remainder R,
// divisor B, count Q, the compare/zero status and the result registers.
module div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ld,
  input  logic             i_sub,
  input  logic             i_ld_out,
  input  logic             i_dz,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_ge,
  output logic             o_bz,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_q_inc;

  // Subtraction is only committed when R>=B, and Q is bounded by the
  // dividend, so neither needs a wider result.
  assign w_diff  = r_r - r_b;
  assign w_q_inc = r_q + {{(WIDTH-1){1'b0}}, 1'b1};
  assign o_ge    = (r_r >= r_b);
  assign o_bz    = (r_b == '0);

  // Working registers: load operands on start, step on each subtraction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r <= '0;
      r_b <= '0;
      r_q <= '0;
    end else if (i_ld) begin
      r_r <= i_dividend;
      r_b <= i_divisor;
      r_q <= '0;
    end else if (i_sub) begin
      r_r <= w_diff;
      r_q <= w_q_inc;
    end
  end

  // Result registers: updated only on the edge that enters DONE, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (i_ld_out) begin
      r_quotient    <= i_dz ? {WIDTH{1'b1}} : r_q;
      r_remainder   <= r_r;
      r_div_by_zero <= i_dz;
    end
  end

  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule

// File: rtl/div_repeated_sub.sv
// Sequential unsigned divider by repeated subtraction. The FSM here drives
// the div_datapath controls; latency is quotient+1 cycles from start.
module div_repeated_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t r_state;
  state_t w_next;
  logic   w_ld;
  logic   w_sub;
  logic   w_ld_out;
  logic   w_dz;
  logic   w_ge;
  logic   w_bz;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and datapath controls; divide-by-zero takes priority over R>=B.
  always_comb begin
    w_next   = IDLE;
    w_ld     = 1'b0;
    w_sub    = 1'b0;
    w_ld_out = 1'b0;
    w_dz     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_ld   = 1'b1;
          w_next = ITER;
        end else begin
          w_next = IDLE;
        end
      end
      ITER: begin
        busy = 1'b1;
        if (w_bz) begin
          w_ld_out = 1'b1;
          w_dz     = 1'b1;
          w_next   = DONE;
        end else if (w_ge) begin
          w_sub  = 1'b1;
          w_next = ITER;
        end else begin
          w_ld_out = 1'b1;
          w_next   = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  div_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ld         (w_ld),
    .i_sub        (w_sub),
    .i_ld_out     (w_ld_out),
    .i_dz         (w_dz),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .o_ge         (w_ge),
    .o_bz         (w_bz),
    .o_quotient   (quotient),
    .o_remainder  (remainder),
    .o_div_by_zero(div_by_zero)
  );

endmodule

// File: tb/tb_div_repeated_sub.sv
// Self-checking bench for div_repeated_sub (WIDTH=16): table of divisions
// with expected results and latency, plus start-held and async-reset cases.
module tb_div_repeated_sub;

  localparam int W = 16;
  localparam int TIMEOUT = 70000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[8];
  int   total = 0;
  int   bad = 0;

  div_repeated_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive a request on the next edge and queue its expected result.
  task automatic start_op(input vec_t v);
    @(negedge clk);
    dividend = v.a;
    divisor  = v.b;
    start    = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges after the sampling edge until done, then compare to the queue head.
  task automatic wait_result(input string tag);
    vec_t e;
    int   cnt = 0;
    bit   seen = 0;
    bit   busy_ok = 1;
    e = sb.pop_front();
    while (!seen && cnt < TIMEOUT) begin
      @(posedge clk);
      #1;
      cnt++;
      if (done) seen = 1;
      else if (busy !== 1'b1) busy_ok = 0;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'(cnt), 32'(e.lat));
    end else begin
      check({tag, "_latency"}, 32'(cnt), 32'(e.lat));
      check({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "_quotient"}, 32'(quotient), 32'(e.q));
      check({tag, "_remainder"}, 32'(remainder), 32'(e.r));
      check({tag, "_dz"}, 32'(div_by_zero), 32'(e.dz));
      // Following IDLE cycle: done gone, result still held.
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_hold_q"}, 32'(quotient), 32'(e.q));
    end
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{a: 100,   b: 7,  q: 14,       r: 2,  dz: 0, lat: 15};
    tbl[1] = '{a: 5,     b: 9,  q: 0,        r: 5,  dz: 0, lat: 1};
    tbl[2] = '{a: 42,    b: 42, q: 1,        r: 0,  dz: 0, lat: 2};
    tbl[3] = '{a: 42,    b: 0,  q: 16'hFFFF, r: 42, dz: 1, lat: 1};
    tbl[4] = '{a: 10,    b: 3,  q: 3,        r: 1,  dz: 0, lat: 4};
    tbl[5] = '{a: 0,     b: 5,  q: 0,        r: 0,  dz: 0, lat: 1};
    tbl[6] = '{a: 0,     b: 0,  q: 16'hFFFF, r: 0,  dz: 1, lat: 1};
    tbl[7] = '{a: 65535, b: 1,  q: 65535,    r: 0,  dz: 0, lat: 65536};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven divisions
    for (int i = 0; i < 8; i++) begin
      start_op(tbl[i]);
      wait_result($sformatf("vec%0d", i));
    end

    // Start held high, operands changed mid-operation; second op picks up
    // the operands present at the first IDLE edge.
    @(negedge clk);
    dividend = 200;
    divisor  = 10;
    start    = 1'b1;
    v = '{a: 200, b: 10, q: 20, r: 0, dz: 0, lat: 21};
    sb.push_back(v);
    @(posedge clk);
    #1;
    dividend = 50;
    divisor  = 5;
    begin
      int cnt = 0;
      bit seen = 0;
      vec_t e;
      e = sb.pop_front();
      while (!seen && cnt < TIMEOUT) begin
        @(posedge clk);
        #1;
        cnt++;
        if (done) seen = 1;
      end
      check("held_latency", 32'(cnt), 32'(e.lat));
      check("held_quotient", 32'(quotient), 32'(e.q));
      check("held_remainder", 32'(remainder), 32'(e.r));
      dividend = 77;
      divisor  = 8;
      @(posedge clk);
      #1;
      check("held_idle_busy", 32'(busy), 32'd0);
      v = '{a: 77, b: 8, q: 9, r: 5, dz: 0, lat: 10};
      sb.push_back(v);
      @(posedge clk);
      #1;
      check("held_restart_busy", 32'(busy), 32'd1);
      start = 1'b0;
      wait_result("held_second");
    end

    // Asynchronous reset in the middle of 1000/3
    @(negedge clk);
    dividend = 1000;
    divisor  = 3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_quotient", 32'(quotient), 32'd0);
    check("arst_remainder", 32'(remainder), 32'd0);
    check("arst_dz", 32'(div_by_zero), 32'd0);
    begin
      bit any_done = 0;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        if (done) any_done = 1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        if (done || busy) any_done = 1;
      end
      check("arst_no_done", 32'(any_done), 32'd0);
    end
    v = '{a: 9, b: 4, q: 2, r: 1, dz: 0, lat: 3};
    start_op(v);
    wait_result("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
